multi_switch_led_toggle: RTL and testbench
==========================================

// Module: multi_switch_led_toggle
// PURPOSE
//  N-channel LED toggler driven by raw mechanical switches.
//  Each channel synchronises its switch, debounces it, detects the selected edge and toggles its LED.
//  Sits between the board switch pins and LED pins.
//  Replaces single-channel, undebounced edge toggling for multi-switch designs.
// PARAMETERS
//  NUM_CH          4       number of independent switch/LED channels (>=1)
//  DEBOUNCE_LIMIT  250000  clocks a synced level must stay stable to qualify (>=2; 10 ms @ 25 MHz)
//  EDGE_MODE       0       0 = toggle on release (1->0); 1 = on press (0->1); 2 = on both
//  SYNC_STAGES     2       synchroniser flops per channel (>=2)
// PORTS
//  i_Clk           in   1       system clock
//  i_Rst           in   1       reset, asynchronous, active-high
//  i_Switch        in   NUM_CH  raw switch levels, asynchronous to i_Clk
//  i_Clear         in   1       synchronous clear of all LEDs
//  o_LED           out  NUM_CH  registered LED states
//  o_Toggle_Pulse  out  NUM_CH  only with LED_TOGGLE_PULSE_EN; 1-cycle qualified-edge strobe
// BEHAVIOUR
//  Reset
//   - All flops cleared asynchronously on i_Rst=1: sync chain, counters, debounced state, init flag, o_LED, o_Toggle_Pulse.
//  Per-channel pipeline
//   - SYNC_STAGES-flop synchroniser, then the debouncer:
//     counter cnt of width $clog2(DEBOUNCE_LIMIT), debounced level deb, init flag ini.
//  Debouncer states per channel: INIT (ini=0), STABLE (ini=1, synced==deb), COUNTING (ini=1, synced!=deb).
//   - INIT
//     - cnt increments every cycle; it restarts at 0 if the synced level changes.
//     - At cnt==DEBOUNCE_LIMIT-1: deb<=synced, ini<=1, cnt<=0. No edge is produced.
//     - Result: a switch held in either level at reset release never toggles.
//   - STABLE: cnt held at 0.
//   - COUNTING
//     - cnt increments each cycle.
//     - If synced returns to deb before terminal count: cnt<=0, back to STABLE (glitch rejected).
//     - At cnt==DEBOUNCE_LIMIT-1: deb<=synced, cnt<=0.
//     - This qualified change is an edge: rise if deb 0->1, fall if 1->0.
//  Toggle
//   - o_LED[k] inverts on the same clock edge that deb[k] updates, if the edge matches EDGE_MODE.
//   - Latency: an i_Switch change held stable flips o_LED SYNC_STAGES+DEBOUNCE_LIMIT rising edges after the first sampling edge.
//   - Pulses shorter than DEBOUNCE_LIMIT cycles at the synchroniser output produce no toggle.
//  Clear
//   - i_Clear=1 forces every o_LED to 0 on the next edge.
//   - Clear wins over a coincident toggle.
//   - Debouncer state is untouched by i_Clear.
//  Channels are fully independent; simultaneous qualified edges on several channels all toggle in the same cycle.
//  i_Rst asserted mid-count:
//   - Abandons the count; the channel re-enters INIT after release.
//   - No toggle occurs from the interrupted edge.
//  Illegal EDGE_MODE values (>2): no channel ever toggles.
// CONFIGURATION
//  LED_TOGGLE_PULSE_EN
//   - Defined: port o_Toggle_Pulse exists. Bit k is high for exactly the one cycle in which channel k has a qualified edge matching EDGE_MODE.
//   - The pulse is asserted even when i_Clear suppresses the LED toggle. It is never asserted for the INIT qualification.
//   - Undefined: port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package led_toggle_pkg
//   - localparams EDGE_FALL=0, EDGE_RISE=1, EDGE_BOTH=2.
//   - Debouncer state encoding constants.
//  Sub-module switch_debounce (params DEBOUNCE_LIMIT, SYNC_STAGES)
//   - Ports: i_Clk, i_Rst, i_Switch, o_Level, o_Rise, o_Fall. o_Rise/o_Fall are 1-cycle pulses aligned to the deb update.
//   - Instantiated NUM_CH times in a generate loop.
//  Top level holds EDGE_MODE select, clear/toggle registers and the optional pulse outputs.
// TESTING (NUM_CH=2, DEBOUNCE_LIMIT=4, SYNC_STAGES=2 unless stated)
//  1. Reset release, i_Switch=00; wait 10 cycles -> o_LED=00.
//     Then ch0 0->1, hold 10, 1->0, EDGE_MODE=0 -> o_LED[0] rises exactly 6 edges after the 1->0 sample; o_LED[1]=0.
//  2. ch0 high for 3 cycles then low, EDGE_MODE=1 -> no toggle (glitch rejected); a 4-cycle-stable high toggles.
//  3. Reset released with i_Switch=11, EDGE_MODE=0, hold 20 cycles -> o_LED=00.
//     Then release both in the same cycle -> o_LED=11 on the same edge.
//  4. EDGE_MODE=2: ch1 press, hold 8, release, hold 8 -> o_LED[1] sequence 0->1->0, each change 6 edges after its input change.
//  5. i_Clear=1 on the cycle ch0 qualifies with o_LED[0]=0 -> o_LED[0] stays 0.
//     With LED_TOGGLE_PULSE_EN, o_Toggle_Pulse[0]=1 that cycle only.
//  6. i_Rst asserted 2 cycles into a ch0 count with o_LED=01 -> o_LED=00 immediately (async).
//     After release, holding the new level produces no toggle.

Source files
------------

// File: rtl/led_toggle_pkg.sv
// Shared constants for the multi-channel switch/LED toggler: edge-select
// codes, per-channel debouncer state encoding and the edge-select helper.
package led_toggle_pkg;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_BOTH = 2;

  localparam logic [1:0] DEB_INIT     = 2'd0;
  localparam logic [1:0] DEB_STABLE   = 2'd1;
  localparam logic [1:0] DEB_COUNTING = 2'd2;

  // Picks the qualified edges that should toggle an LED; unknown modes select nothing.
  function automatic logic edge_match(input int mode, input logic rise, input logic fall);
    case (mode)
      EDGE_FALL: return fall;
      EDGE_RISE: return rise;
      EDGE_BOTH: return rise | fall;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: synchroniser followed by a terminal-count debouncer.
// o_Rise/o_Fall are combinational one-cycle strobes, high in the cycle whose
// closing clock edge updates the debounced level, so a downstream register
// can act on the same edge.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | after reset; qualify the first stable level, no edge out
// STABLE   | synced level equals debounced level; counter parked at 0
// COUNTING | synced level differs; count towards terminal count
module switch_debounce
  import led_toggle_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  localparam int              CW     = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0]   CNT_TC = CW'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_deb;
  logic                   r_ini;
  logic                   w_synced;
  logic                   w_tc;
  logic                   w_qual;
  logic [1:0]             w_state;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_tc     = (r_cnt == CNT_TC);

  // Shift the raw switch level through the synchroniser chain.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_Switch};
  end

  // Debouncer state is implied by the init flag and the level comparison.
  always_comb begin
    w_state = DEB_STABLE;
    if (!r_ini)                 w_state = DEB_INIT;
    else if (w_synced != r_deb) w_state = DEB_COUNTING;
  end

  // Counter and debounced level; during INIT r_deb tracks the candidate level.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
      r_ini <= 1'b0;
    end else begin
      case (w_state)
        DEB_INIT: begin
          if (w_synced != r_deb) begin
            r_deb <= w_synced;
            r_cnt <= '0;
          end else if (w_tc) begin
            r_ini <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DEB_COUNTING: begin
          if (w_tc) begin
            r_deb <= w_synced;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign w_qual  = (w_state == DEB_COUNTING) && w_tc;
  assign o_Rise  = w_qual &  w_synced;
  assign o_Fall  = w_qual & ~w_synced;
  assign o_Level = r_deb;

endmodule

// File: rtl/multi_switch_led_toggle.sv
// N-channel LED toggler fed by raw mechanical switches. Each channel is
// synchronised and debounced; a qualified edge matching EDGE_MODE inverts
// its LED. i_Clear zeroes all LEDs and wins over a coincident toggle.
// Optional build macro LED_TOGGLE_PULSE_EN adds o_Toggle_Pulse, a registered
// one-cycle strobe per channel aligned with the LED update (asserted even
// when i_Clear suppresses the toggle).
module multi_switch_led_toggle
  import led_toggle_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int EDGE_MODE      = 0,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic              i_Clear,
  output logic [NUM_CH-1:0] o_LED
`ifdef LED_TOGGLE_PULSE_EN
  ,
  output logic [NUM_CH-1:0] o_Toggle_Pulse
`endif
);

  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_edge;
  logic [NUM_CH-1:0] r_led;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    switch_debounce #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_deb (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Switch(i_Switch[gi]),
      .o_Level (),
      .o_Rise  (w_rise[gi]),
      .o_Fall  (w_fall[gi])
    );
    assign w_edge[gi] = edge_match(EDGE_MODE, w_rise[gi], w_fall[gi]);
  end

  // LED register: clear has priority, otherwise invert on selected edges.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)        r_led <= '0;
    else if (i_Clear) r_led <= '0;
    else              r_led <= r_led ^ w_edge;
  end

  assign o_LED = r_led;

`ifdef LED_TOGGLE_PULSE_EN
  logic [NUM_CH-1:0] r_pulse;

  // Strobe every selected edge, independent of i_Clear.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_pulse <= '0;
    else       r_pulse <= w_edge;
  end

  assign o_Toggle_Pulse = r_pulse;
`endif

endmodule

// File: tb/tb_multi_switch_led_toggle.sv
// Bench: four DUT copies (EDGE_MODE 0..3, mode 3 illegal) share the same
// stimulus. Expected qualified edges are queued at drive time with their due
// cycle; the tick task retires them into an expected LED/pulse image that
// every test compares against the DUTs each cycle.
module tb_multi_switch_led_toggle;

  localparam int NCH = 2;
  localparam int DL  = 4;
  localparam int SS  = 2;
  localparam int NM  = 4;
  localparam int LAT = SS + DL;

  typedef struct {
    int   cyc;
    int   ch;
    logic rise;
  } ev_t;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           clear = 1'b0;
  logic [NCH-1:0] sw    = '0;
  logic [NCH-1:0] led_w [NM];
  logic [15:0]    obs_all;
  logic [15:0]    exp_all;
  logic [7:0]     exp_led = '0;
  logic [7:0]     exp_pls = '0;
  ev_t            q[$];
  int             cyc    = 0;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

`ifdef LED_TOGGLE_PULSE_EN
  logic [NCH-1:0] pls_w [NM];
  assign obs_all = {pls_w[3], pls_w[2], pls_w[1], pls_w[0], led_w[3], led_w[2], led_w[1], led_w[0]};
  assign exp_all = {exp_pls, exp_led};
`else
  assign obs_all = {8'h00, led_w[3], led_w[2], led_w[1], led_w[0]};
  assign exp_all = {8'h00, exp_led};
`endif

  for (genvar m = 0; m < NM; m++) begin : g_dut
    multi_switch_led_toggle #(
      .NUM_CH        (NCH),
      .DEBOUNCE_LIMIT(DL),
      .EDGE_MODE     (m),
      .SYNC_STAGES   (SS)
    ) u_dut (
      .i_Clk   (clk),
      .i_Rst   (rst),
      .i_Switch(sw),
      .i_Clear (clear),
      .o_LED   (led_w[m])
`ifdef LED_TOGGLE_PULSE_EN
      ,
      .o_Toggle_Pulse(pls_w[m])
`endif
    );
  end

  function automatic logic mode_hits(input int m, input logic rise);
    return (m == 2) || (m == 0 && !rise) || (m == 1 && rise);
  endfunction

  // Advance one clock and retire due edges into the expected image.
  task automatic tick();
    logic clr_s;
    ev_t  ev;
    clr_s = clear;
    @(posedge clk);
    #1;
    cyc++;
    exp_pls = '0;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      ev = q.pop_front();
      for (int m = 0; m < NM; m++) begin
        if (mode_hits(m, ev.rise)) begin
          exp_pls[2*m+ev.ch] = 1'b1;
          exp_led[2*m+ev.ch] = ~exp_led[2*m+ev.ch];
        end
      end
    end
    if (clr_s) exp_led = '0;
  endtask

  task automatic drive(input int ch, input logic val, input logic qual);
    ev_t e;
    sw[ch] = val;
    if (qual) begin
      e.cyc  = cyc + LAT;
      e.ch   = ch;
      e.rise = val;
      q.push_back(e);
    end
  endtask

  task automatic model_reset();
    exp_led = '0;
    exp_pls = '0;
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 14; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      checks++;
      if (obs_all !== exp_all) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_release();
    for (int i = 0; i < 22; i++) begin
      if (i == 0)  drive(0, 1'b1, 1'b1);
      if (i == 10) drive(0, 1'b0, 1'b1);
      tick();
      checks++;
      if (obs_all !== exp_all) begin
        errors++;
        $display("FAIL release cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 28; i++) begin
      if (i == 0)  drive(0, 1'b1, 1'b0);
      if (i == 3)  drive(0, 1'b0, 1'b0);
      if (i == 12) drive(0, 1'b1, 1'b1);
      if (i == 16) drive(0, 1'b0, 1'b1);
      tick();
      checks++;
      if (obs_all !== exp_all) begin
        errors++;
        $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_init_high();
    rst = 1'b1;
    sw  = 2'b11;
    model_reset();
    #1;
    checks++;
    if (obs_all !== exp_all) begin
      errors++;
      $display("FAIL init_high_rst cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
    end
    for (int i = 0; i < 32; i++) begin
      if (i == 2) rst = 1'b0;
      if (i == 22) begin
        drive(0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b1);
      end
      tick();
      checks++;
      if (obs_all !== exp_all) begin
        errors++;
        $display("FAIL init_high cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_both_edges();
    for (int i = 0; i < 20; i++) begin
      if (i == 0)  clear = 1'b1;
      if (i == 1)  clear = 1'b0;
      if (i == 2)  drive(1, 1'b1, 1'b1);
      if (i == 10) drive(1, 1'b0, 1'b1);
      tick();
      checks++;
      if (obs_all !== exp_all) begin
        errors++;
        $display("FAIL both_edges cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 22; i++) begin
      if (i == 0)  clear = 1'b1;
      if (i == 1)  clear = 1'b0;
      if (i == 2)  drive(0, 1'b1, 1'b1);
      if (i == 7)  clear = 1'b1;
      if (i == 8)  clear = 1'b0;
      if (i == 12) drive(0, 1'b0, 1'b1);
      tick();
      checks++;
      if (obs_all !== exp_all) begin
        errors++;
        $display("FAIL clear cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(0, 1'b1, 1'b0);
      tick();
      checks++;
      if (obs_all !== exp_all) begin
        errors++;
        $display("FAIL mid_pre cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
      end
    end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_all !== exp_all) begin
      errors++;
      $display("FAIL mid_async cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
    end
    for (int i = 0; i < 18; i++) begin
      if (i == 1) rst = 1'b0;
      tick();
      checks++;
      if (obs_all !== exp_all) begin
        errors++;
        $display("FAIL mid_post cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_glitch();
    test_init_high();
    test_both_edges();
    test_clear();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
